exe_stage_pipe: RTL and testbench
=================================

# exe_stage_pipe

Parametrised, registered execute stage for the ARM pipeline. It accepts one decoded instruction per valid/ready handshake and forms the second operand (shifter / immediate / memory offset). It evaluates the ALU and flags, and also executes MUL/MLA on an iterative multiplier. The result, branch target and forwarded control land in an output register that feeds the MEM stage under its own valid/ready handshake, with synchronous flush from hazard/branch logic.

## Interface
- WIDTH, 32, datapath width (≥ 16)
- IMM_WIDTH, 24, branch offset field width
- BITS_PER_CYCLE, 2, multiplier bits retired per cycle; must divide WIDTH; N = WIDTH/BITS_PER_CYCLE
- CTRL_W, 8, opaque sideband (wb_en, dest, …) carried through unchanged

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of in-flight and held instruction
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- exe_cmd  in  4  operation code
- mem_r_en  in  1  load
- mem_w_en  in  1  store
- pc  in  WIDTH  PC of the instruction
- val_rn  in  WIDTH  first operand / multiplicand
- val_rm  in  WIDTH  register operand / multiplier / store data
- val_acc  in  WIDTH  MLA accumulator
- imm  in  1  immediate-form operand 2
- shift_operand  in  12  operand-2 field
- signed_imm  in  IMM_WIDTH  branch offset, in words
- sr  in  4  current flags {N,Z,C,V}
- ctrl_in  in  CTRL_W  sideband
- out_valid  out  1  output register holds a result
- out_ready  in  1  downstream consumes
- alu_result  out  WIDTH  result / effective address
- br_addr  out  WIDTH  branch target
- status  out  4  new flags {N,Z,C,V}
- out_mem_r_en  out  1  registered mem_r_en
- out_mem_w_en  out  1  registered mem_w_en
- out_store_data  out  WIDTH  registered val_rm
- ctrl_out  out  CTRL_W  registered ctrl_in

## Operation
- exe_cmd encoding:
  - MOV 0001, MVN 1001.
  - ADD 0010, ADC 0011, SUB 0100, SBC 0101.
  - AND 0110, ORR 0111, EOR 1000.
  - MUL 1010, MLA 1011.
  - Any other code: result 0, status = sr.
- val2 selection:
  - mem_r_en|mem_w_en: zero-extended shift_operand.
  - imm: shift_operand[7:0] rotated right by 2·shift_operand[11:8].
  - Otherwise: val_rm shifted by shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR), amount shift_operand[11:7].
- Arithmetic, all mod 2^WIDTH:
  - ADC adds C.
  - SUB: rn − val2.
  - SBC: rn − val2 − !C.
- Flags:
  - N = result MSB; Z = (result == 0).
  - Add/sub ops: C = carry-out (subtraction: C = no borrow); V = signed overflow.
  - Logic ops, MOV/MVN and MUL/MLA: C, V copied from sr.
- MUL: low WIDTH bits of val_rn·val_rm. MLA: that value + val_acc. val2 is not used.
- br_addr = pc + (sign-extend(signed_imm) << 2), mod 2^WIDTH.
- States and transitions:
  - EMPTY: in_ready = 1.
    - Accept of a non-multiply goes to FULL.
    - Accept of MUL/MLA goes to BUSY.
  - BUSY: in_ready = 0; one iteration per cycle.
    - After N iterations, the result is loaded and the state goes to FULL.
  - FULL: out_valid = 1; in_ready = out_ready.
    - out_ready=1 with a new accept goes to FULL or BUSY per the new op.
    - out_ready=1 with no accept goes to EMPTY.
    - out_ready=0: hold.
- flush has priority over everything. Next state is EMPTY; a multiply is aborted; a same-cycle in_valid is not accepted.
- The output register and sideband are stable while out_valid && !out_ready.

## Timing
- Reset values:
  - State EMPTY, so in_ready = 1.
  - out_valid, alu_result, br_addr, status, out_mem_r_en, out_mem_w_en, out_store_data and ctrl_out are all 0.
- Latency from the accepting edge to out_valid high:
  - Non-multiply: 1 cycle.
  - MUL/MLA: N cycles (16 at defaults).
- Throughput: 1 instruction/cycle for non-multiply ops with out_ready held high. A multiply blocks for N cycles.
- Operand inputs are sampled only on the accepting edge; they may change during BUSY.
- rst during BUSY or FULL returns to the reset values immediately; no result is emitted.

## Test plan
- Immediate ADD, then load effective address:
  - ADD, imm=1, shift_operand=0x003, val_rn=5 → 1 cycle later out_valid=1, alu_result=8, status=0000.
  - mem_r_en=1, shift_operand=0xFFF, val_rn=0x1000 → alu_result=0x1FFF.
- SUB, register val_rm=5, shift_operand=0, val_rn=3 → alu_result=0xFFFFFFFE, status=1000. Then ADC 0x7FFFFFFF+0 with sr C=1 → 0x80000000, status=1001.
- Multiply (defaults):
  - MUL 7·6: in_ready=0 for 16 cycles, then out_valid with 42, N/Z=00, C/V = sr[1:0].
  - MLA 7·6 with val_acc=100 → 142.
- Backpressure: out_ready=0 for 3 cycles with in_valid high → outputs frozen, in_ready=0. Release → 4 back-to-back ADDs retire on 4 consecutive cycles.
- Flush and reset during a multiply: flush on cycle 5 of a MUL → out_valid never rises, in_ready=1 the next cycle. rst asserted in FULL → all outputs 0 asynchronously.
- Branch target: pc=0x100, signed_imm=0xFFFFFF → br_addr=0xFC; signed_imm=0x000004 → br_addr=0x110.

Source files
------------

// File: rtl/exe_stage_pipe_if.sv
// Handshake and data bundle for the execute stage: upstream instruction side and
// downstream MEM-stage side. The stage uses the slave modport.
interface exe_stage_pipe_if #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 24,
    parameter int CTRL_W    = 8
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           exe_cmd;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     val_rn;
    logic [WIDTH-1:0]     val_rm;
    logic [WIDTH-1:0]     val_acc;
    logic                 imm;
    logic [11:0]          shift_operand;
    logic [IMM_WIDTH-1:0] signed_imm;
    logic [3:0]           sr;
    logic [CTRL_W-1:0]    ctrl_in;

    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     alu_result;
    logic [WIDTH-1:0]     br_addr;
    logic [3:0]           status;
    logic                 out_mem_r_en;
    logic                 out_mem_w_en;
    logic [WIDTH-1:0]     out_store_data;
    logic [CTRL_W-1:0]    ctrl_out;

    modport master (
        output flush, in_valid, exe_cmd, mem_r_en, mem_w_en, pc, val_rn, val_rm,
               val_acc, imm, shift_operand, signed_imm, sr, ctrl_in, out_ready,
        input  in_ready, out_valid, alu_result, br_addr, status, out_mem_r_en,
               out_mem_w_en, out_store_data, ctrl_out
    );

    modport slave (
        input  flush, in_valid, exe_cmd, mem_r_en, mem_w_en, pc, val_rn, val_rm,
               val_acc, imm, shift_operand, signed_imm, sr, ctrl_in, out_ready,
        output in_ready, out_valid, alu_result, br_addr, status, out_mem_r_en,
               out_mem_w_en, out_store_data, ctrl_out
    );
endinterface

// File: rtl/exe_stage_pipe.sv
// Registered ARM execute stage: operand-2 shifter, ALU with flags, branch target
// adder and an iterative MUL/MLA unit, feeding a valid/ready output register.
module exe_stage_pipe #(
    parameter int WIDTH          = 32,
    parameter int IMM_WIDTH      = 24,
    parameter int BITS_PER_CYCLE = 2,
    parameter int CTRL_W         = 8
) (
    input logic           clk,
    input logic           rst,
    exe_stage_pipe_if.slave bus
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;
    localparam logic [3:0] CMD_MLA = 4'b1011;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t               state;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     alu_result_q;
    logic [WIDTH-1:0]     br_addr_q;
    logic [3:0]           status_q;
    logic                 mem_r_en_q;
    logic                 mem_w_en_q;
    logic [WIDTH-1:0]     store_data_q;
    logic [CTRL_W-1:0]    ctrl_q;

    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     macc;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           mul_cv;

    logic                 accept;
    logic                 is_mul;
    logic [WIDTH-1:0]     val2;
    logic [WIDTH-1:0]     b_op;
    logic                 cin;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_res;
    logic [3:0]           alu_flags;
    logic [WIDTH-1:0]     br_target;
    logic [WIDTH-1:0]     partial;
    logic [WIDTH-1:0]     macc_next;

    function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input logic [5:0] s);
        logic [2*WIDTH-1:0] d;
        d = {x, x} >> (int'(s) % WIDTH);
        return d[WIDTH-1:0];
    endfunction

    assign bus.in_ready       = (state == EMPTY) || ((state == FULL) && bus.out_ready);
    assign accept             = bus.in_valid && bus.in_ready && !bus.flush;
    assign is_mul             = (bus.exe_cmd == CMD_MUL) || (bus.exe_cmd == CMD_MLA);

    assign bus.out_valid      = out_valid_q;
    assign bus.alu_result     = alu_result_q;
    assign bus.br_addr        = br_addr_q;
    assign bus.status         = status_q;
    assign bus.out_mem_r_en   = mem_r_en_q;
    assign bus.out_mem_w_en   = mem_w_en_q;
    assign bus.out_store_data = store_data_q;
    assign bus.ctrl_out       = ctrl_q;

    assign br_target = bus.pc + ({{(WIDTH-IMM_WIDTH){bus.signed_imm[IMM_WIDTH-1]}}, bus.signed_imm} << 2);

    // Operand 2: memory offsets win over the immediate/register forms.
    always_comb begin
        val2 = '0;
        if (bus.mem_r_en || bus.mem_w_en) begin
            val2 = {{(WIDTH-12){1'b0}}, bus.shift_operand};
        end else if (bus.imm) begin
            val2 = ror({{(WIDTH-8){1'b0}}, bus.shift_operand[7:0]},
                       {1'b0, bus.shift_operand[11:8], 1'b0});
        end else begin
            case (bus.shift_operand[6:5])
                2'b00:   val2 = bus.val_rm << bus.shift_operand[11:7];
                2'b01:   val2 = bus.val_rm >> bus.shift_operand[11:7];
                2'b10:   val2 = $signed(bus.val_rm) >>> bus.shift_operand[11:7];
                default: val2 = ror(bus.val_rm, {1'b0, bus.shift_operand[11:7]});
            endcase
        end
    end

    // Subtraction reuses the adder as rn + ~val2 + carry-in, so C is "no borrow".
    always_comb begin
        b_op = ((bus.exe_cmd == CMD_SUB) || (bus.exe_cmd == CMD_SBC)) ? ~val2 : val2;
        case (bus.exe_cmd)
            CMD_ADC, CMD_SBC: cin = bus.sr[1];
            CMD_SUB:          cin = 1'b1;
            default:          cin = 1'b0;
        endcase
        sum = {1'b0, bus.val_rn} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        alu_res   = '0;
        alu_flags = bus.sr;
        case (bus.exe_cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_AND: alu_res = bus.val_rn & val2;
            CMD_ORR: alu_res = bus.val_rn | val2;
            CMD_EOR: alu_res = bus.val_rn ^ val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_res = sum[WIDTH-1:0];
            default: alu_res = '0;
        endcase
        case (bus.exe_cmd)
            CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR:
                alu_flags = {alu_res[WIDTH-1], alu_res == '0, bus.sr[1:0]};
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC:
                alu_flags = {alu_res[WIDTH-1], alu_res == '0, sum[WIDTH],
                             (bus.val_rn[WIDTH-1] == b_op[WIDTH-1]) &&
                             (sum[WIDTH-1] != bus.val_rn[WIDTH-1])};
            default: alu_flags = bus.sr;
        endcase
    end

    assign partial   = mcand * {{(WIDTH-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
    assign macc_next = macc + partial;

    // Control FSM plus output register; sideband is captured at accept time so
    // a multiply only has to fill in alu_result/status when it completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            br_addr_q    <= '0;
            status_q     <= '0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            store_data_q <= '0;
            ctrl_q       <= '0;
            mcand        <= '0;
            mplier       <= '0;
            macc         <= '0;
            cnt          <= '0;
            mul_cv       <= '0;
        end else if (bus.flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            br_addr_q    <= br_target;
            mem_r_en_q   <= bus.mem_r_en;
            mem_w_en_q   <= bus.mem_w_en;
            store_data_q <= bus.val_rm;
            ctrl_q       <= bus.ctrl_in;
            if (is_mul) begin
                state       <= BUSY;
                out_valid_q <= 1'b0;
                mcand       <= bus.val_rn;
                mplier      <= bus.val_rm;
                macc        <= (bus.exe_cmd == CMD_MLA) ? bus.val_acc : '0;
                cnt         <= '0;
                mul_cv      <= bus.sr[1:0];
            end else begin
                state        <= FULL;
                out_valid_q  <= 1'b1;
                alu_result_q <= alu_res;
                status_q     <= alu_flags;
            end
        end else begin
            case (state)
                BUSY: begin
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    macc   <= macc_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(N-1)) begin
                        state        <= FULL;
                        out_valid_q  <= 1'b1;
                        alu_result_q <= macc_next;
                        status_q     <= {macc_next[WIDTH-1], macc_next == '0, mul_cv};
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed self-checking bench for exe_stage_pipe at default parameters.
module tb_exe_stage_pipe;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   check_cnt;

    exe_stage_pipe_if #(.WIDTH(32), .IMM_WIDTH(24), .CTRL_W(8)) bus ();

    exe_stage_pipe #(.WIDTH(32), .IMM_WIDTH(24), .BITS_PER_CYCLE(2), .CTRL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_idle();
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.exe_cmd       = 4'b0000;
        bus.mem_r_en      = 1'b0;
        bus.mem_w_en      = 1'b0;
        bus.pc            = 32'h0;
        bus.val_rn        = 32'h0;
        bus.val_rm        = 32'h0;
        bus.val_acc       = 32'h0;
        bus.imm           = 1'b0;
        bus.shift_operand = 12'h0;
        bus.signed_imm    = 24'h0;
        bus.sr            = 4'b0000;
        bus.ctrl_in       = 8'h00;
        bus.out_ready     = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for exactly one edge, then drops in_valid.
    task automatic send(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                        input logic im, input logic [11:0] so);
        bus.exe_cmd       = cmd;
        bus.val_rn        = rn;
        bus.val_rm        = rm;
        bus.imm           = im;
        bus.shift_operand = so;
        bus.in_valid      = 1'b1;
        step();
        bus.in_valid      = 1'b0;
    endtask

    task automatic test_reset();
        check_cnt++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready);
        else pass_cnt++;
        check_cnt++;
        if ({bus.out_valid, bus.alu_result, bus.br_addr, bus.status, bus.out_mem_r_en,
             bus.out_mem_w_en, bus.out_store_data, bus.ctrl_out} !== '0)
            $display("[TB] FAIL reset_outputs got v=%b res=%h br=%h st=%b", bus.out_valid,
                     bus.alu_result, bus.br_addr, bus.status);
        else pass_cnt++;
    endtask

    task automatic test_add_imm_load();
        bus.sr = 4'b0000;
        send(4'b0010, 32'd5, 32'd0, 1'b1, 12'h003);
        check_cnt++;
        if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd8 || bus.status !== 4'b0000)
            $display("[TB] FAIL add_imm got v=%b res=%h st=%b want 1/00000008/0000",
                     bus.out_valid, bus.alu_result, bus.status);
        else pass_cnt++;
        bus.mem_r_en = 1'b1;
        bus.ctrl_in  = 8'hA5;
        send(4'b0010, 32'h1000, 32'd0, 1'b0, 12'hFFF);
        bus.mem_r_en = 1'b0;
        check_cnt++;
        if (bus.alu_result !== 32'h1FFF || bus.out_mem_r_en !== 1'b1 || bus.ctrl_out !== 8'hA5)
            $display("[TB] FAIL load_addr got res=%h ren=%b ctrl=%h want 00001fff/1/a5",
                     bus.alu_result, bus.out_mem_r_en, bus.ctrl_out);
        else pass_cnt++;
        bus.mem_w_en = 1'b1;
        send(4'b0010, 32'h2000, 32'hDEADBEEF, 1'b1, 12'h010);
        bus.mem_w_en = 1'b0;
        check_cnt++;
        if (bus.alu_result !== 32'h2010 || bus.out_mem_w_en !== 1'b1 ||
            bus.out_store_data !== 32'hDEADBEEF)
            $display("[TB] FAIL store got res=%h wen=%b data=%h want 00002010/1/deadbeef",
                     bus.alu_result, bus.out_mem_w_en, bus.out_store_data);
        else pass_cnt++;
    endtask

    task automatic test_sub_adc();
        bus.sr = 4'b0000;
        send(4'b0100, 32'd3, 32'd5, 1'b0, 12'h000);
        check_cnt++;
        if (bus.alu_result !== 32'hFFFFFFFE || bus.status !== 4'b1000)
            $display("[TB] FAIL sub_neg got res=%h st=%b want fffffffe/1000",
                     bus.alu_result, bus.status);
        else pass_cnt++;
        bus.sr = 4'b0010;
        send(4'b0011, 32'h7FFFFFFF, 32'd0, 1'b0, 12'h000);
        check_cnt++;
        if (bus.alu_result !== 32'h80000000 || bus.status !== 4'b1001)
            $display("[TB] FAIL adc_ovf got res=%h st=%b want 80000000/1001",
                     bus.alu_result, bus.status);
        else pass_cnt++;
        bus.sr = 4'b0000;
        send(4'b0100, 32'd5, 32'd0, 1'b1, 12'h005);
        check_cnt++;
        if (bus.alu_result !== 32'd0 || bus.status !== 4'b0110)
            $display("[TB] FAIL sub_zero got res=%h st=%b want 00000000/0110",
                     bus.alu_result, bus.status);
        else pass_cnt++;
        bus.sr = 4'b0000;
        send(4'b0101, 32'd10, 32'd3, 1'b0, 12'h000);
        check_cnt++;
        if (bus.alu_result !== 32'd6 || bus.status !== 4'b0010)
            $display("[TB] FAIL sbc_borrow got res=%h st=%b want 00000006/0010",
                     bus.alu_result, bus.status);
        else pass_cnt++;
    endtask

    task automatic test_logic_shift();
        bus.sr = 4'b0010;
        send(4'b1001, 32'd0, 32'd0, 1'b1, 12'h000);
        check_cnt++;
        if (bus.alu_result !== 32'hFFFFFFFF || bus.status !== 4'b1010)
            $display("[TB] FAIL mvn got res=%h st=%b want ffffffff/1010",
                     bus.alu_result, bus.status);
        else pass_cnt++;
        bus.sr = 4'b0001;
        send(4'b0001, 32'd0, 32'h00000001, 1'b0, 12'h260);
        check_cnt++;
        if (bus.alu_result !== 32'h10000000 || bus.status !== 4'b0001)
            $display("[TB] FAIL mov_ror got res=%h st=%b want 10000000/0001",
                     bus.alu_result, bus.status);
        else pass_cnt++;
        bus.sr = 4'b0000;
        send(4'b0111, 32'd0, 32'h80000000, 1'b0, 12'h240);
        check_cnt++;
        if (bus.alu_result !== 32'hF8000000 || bus.status !== 4'b1000)
            $display("[TB] FAIL orr_asr got res=%h st=%b want f8000000/1000",
                     bus.alu_result, bus.status);
        else pass_cnt++;
        send(4'b1000, 32'h0F000000, 32'd0, 1'b1, 12'h4FF);
        check_cnt++;
        if (bus.alu_result !== 32'hF0000000 || bus.status !== 4'b1000)
            $display("[TB] FAIL eor_rotimm got res=%h st=%b want f0000000/1000",
                     bus.alu_result, bus.status);
        else pass_cnt++;
        send(4'b0110, 32'h12345678, 32'd0, 1'b1, 12'h0F0);
        check_cnt++;
        if (bus.alu_result !== 32'h00000070 || bus.status !== 4'b0000)
            $display("[TB] FAIL and_imm got res=%h st=%b want 00000070/0000",
                     bus.alu_result, bus.status);
        else pass_cnt++;
        bus.sr = 4'b0101;
        send(4'b1111, 32'd9, 32'd9, 1'b1, 12'h009);
        check_cnt++;
        if (bus.alu_result !== 32'd0 || bus.status !== 4'b0101)
            $display("[TB] FAIL undef_cmd got res=%h st=%b want 00000000/0101",
                     bus.alu_result, bus.status);
        else pass_cnt++;
    endtask

    task automatic test_multiply(input logic mla, input logic [31:0] acc, input logic [31:0] want);
        int  n;
        bit  busy_ok;
        bus.sr      = 4'b0011;
        bus.val_acc = acc;
        send(mla ? 4'b1011 : 4'b1010, 32'd7, 32'd6, 1'b0, 12'h000);
        bus.val_rn  = 32'hFFFF0000;
        bus.val_rm  = 32'h0000FFFF;
        bus.val_acc = 32'h55555555;
        bus.sr      = 4'b1100;
        n       = 0;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            step();
            n++;
        end
        check_cnt++;
        if (n != 16) $display("[TB] FAIL mul_latency got %0d cycles want 16", n);
        else pass_cnt++;
        check_cnt++;
        if (!busy_ok) $display("[TB] FAIL mul_busy_ready got in_ready high while busy want 0");
        else pass_cnt++;
        check_cnt++;
        if (bus.alu_result !== want || bus.status !== 4'b0011)
            $display("[TB] FAIL mul_result mla=%b got res=%h st=%b want %h/0011",
                     mla, bus.alu_result, bus.status, want);
        else pass_cnt++;
        bus.sr = 4'b0000;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        send(4'b0010, 32'd10, 32'd0, 1'b1, 12'h001);
        bus.exe_cmd = 4'b0010;
        bus.val_rn  = 32'd20;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_cnt++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.alu_result !== 32'd11)
                $display("[TB] FAIL hold_%0d got rdy=%b v=%b res=%h want 0/1/0000000b",
                         i, bus.in_ready, bus.out_valid, bus.alu_result);
            else pass_cnt++;
            step();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.val_rn = 32'd100 + 32'(i);
            step();
            check_cnt++;
            if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd101 + 32'(i))
                $display("[TB] FAIL b2b_%0d got v=%b res=%h want 1/%h",
                         i, bus.out_valid, bus.alu_result, 32'd101 + 32'(i));
            else pass_cnt++;
        end
        bus.in_valid = 1'b0;
        step();
        check_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("[TB] FAIL drain got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_flush_mul();
        bit seen;
        send(4'b1010, 32'd7, 32'd6, 1'b0, 12'h000);
        repeat (4) step();
        bus.flush    = 1'b1;
        bus.exe_cmd  = 4'b0010;
        bus.val_rn   = 32'd1;
        bus.imm      = 1'b1;
        bus.shift_operand = 12'h001;
        bus.in_valid = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("[TB] FAIL flush_state got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
        else pass_cnt++;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        check_cnt++;
        if (seen) $display("[TB] FAIL flush_no_result got out_valid=1 want 0");
        else pass_cnt++;
    endtask

    task automatic test_reset_full();
        bus.out_ready  = 1'b0;
        bus.mem_w_en   = 1'b1;
        bus.pc         = 32'h400;
        bus.signed_imm = 24'h000010;
        bus.ctrl_in    = 8'h3C;
        bus.sr         = 4'b0011;
        send(4'b0010, 32'h100, 32'hCAFEF00D, 1'b1, 12'h023);
        bus.mem_w_en   = 1'b0;
        check_cnt++;
        if (bus.out_valid !== 1'b1 || bus.br_addr !== 32'h440)
            $display("[TB] FAIL full_before_rst got v=%b br=%h want 1/00000440",
                     bus.out_valid, bus.br_addr);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        check_cnt++;
        if ({bus.out_valid, bus.alu_result, bus.br_addr, bus.status, bus.out_mem_r_en,
             bus.out_mem_w_en, bus.out_store_data, bus.ctrl_out} !== '0 || bus.in_ready !== 1'b1)
            $display("[TB] FAIL async_rst got v=%b res=%h br=%h data=%h ctrl=%h want all 0",
                     bus.out_valid, bus.alu_result, bus.br_addr, bus.out_store_data, bus.ctrl_out);
        else pass_cnt++;
        step();
        rst = 1'b0;
        set_idle();
    endtask

    task automatic test_branch();
        bus.pc         = 32'h100;
        bus.signed_imm = 24'hFFFFFF;
        send(4'b0001, 32'd0, 32'd0, 1'b1, 12'h000);
        check_cnt++;
        if (bus.br_addr !== 32'hFC) $display("[TB] FAIL br_back got %h want 000000fc", bus.br_addr);
        else pass_cnt++;
        bus.signed_imm = 24'h000004;
        send(4'b0001, 32'd0, 32'd0, 1'b1, 12'h000);
        check_cnt++;
        if (bus.br_addr !== 32'h110) $display("[TB] FAIL br_fwd got %h want 00000110", bus.br_addr);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        check_cnt = 0;
        rst = 1'b1;
        set_idle();
        #3;
        test_reset();
        step();
        rst = 1'b0;
        test_add_imm_load();
        test_sub_adc();
        test_logic_shift();
        test_multiply(1'b0, 32'd0, 32'd42);
        test_multiply(1'b1, 32'd100, 32'd142);
        step();
        test_back_to_back();
        test_flush_mul();
        test_reset_full();
        test_branch();
        step();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
